// File: rtl/bottle_pkg.sv
// Shared types for the pill-bottling controller: FSM state codes and BCD digit helpers.
package bottle_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FILL  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FULL  = 3'd4
  } state_e;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // One decimal digit of a ripple BCD counter: advances only when the lower digits carry.
  function automatic bcd_t bcd_step(input bcd_t d, input logic cin);
    if (!cin) return d;
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bottle_seg7.sv
// BCD digit to seven-segment glyph, active-high, seg_o = {a,b,c,d,e,f,g}.
module bottle_seg7
  import bottle_pkg::*;
(
  input  bcd_t       digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (digit_i)
      4'd0: seg_o = 7'b1111110;
      4'd1: seg_o = 7'b0110000;
      4'd2: seg_o = 7'b1101101;
      4'd3: seg_o = 7'b1111001;
      4'd4: seg_o = 7'b0110011;
      4'd5: seg_o = 7'b1011011;
      4'd6: seg_o = 7'b1011111;
      4'd7: seg_o = 7'b1110000;
      4'd8: seg_o = 7'b1111111;
      4'd9: seg_o = 7'b1111011;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/bottle.sv
// Pill-bottling controller: fills bottles to a BCD pill target and counts bottles.
// Optional alarm tone on each full bottle is built only when BOTTLE_ALARM_EN is defined.
module bottle
  import bottle_pkg::*;
#(
  parameter int PILL_DIV  = 4,
  parameter int ALARM_CYC = 16
) (
  input  logic CLK_org,
  input  logic rst_n,
  input  logic CLK_Music,
  input  logic isWork,
  input  logic EN_work,
  input  logic EN_set,
  input  logic SET,
  input  logic conti,
  input  logic PrintB,
  input  logic mode_EN,
  input  logic set_high_D, input logic set_high_C, input logic set_high_B, input logic set_high_A,
  input  logic set_low_D,  input logic set_low_C,  input logic set_low_B,  input logic set_low_A,
  output logic light6_D, output logic light6_C, output logic light6_B, output logic light6_A,
  output logic light5_D, output logic light5_C, output logic light5_B, output logic light5_A,
  output logic light4_D, output logic light4_C, output logic light4_B, output logic light4_A,
  output logic light3_D, output logic light3_C, output logic light3_B, output logic light3_A,
  output logic light2_D, output logic light2_C, output logic light2_B, output logic light2_A,
  output logic light1_a, output logic light1_b, output logic light1_c, output logic light1_d,
  output logic light1_e, output logic light1_f, output logic light1_g,
  output logic Speaker
);

  localparam int PW = (PILL_DIV > 1) ? $clog2(PILL_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PILL_DIV - 1);

  state_e state_q, state_d;
  bcd_t tgt_hi_q, tgt_lo_q, tgt_hi_d, tgt_lo_d;
  bcd_t pill_hi_q, pill_lo_q, pill_hi_d, pill_lo_d;
  bcd_t bot_h_q, bot_t_q, bot_u_q, bot_h_d, bot_t_d, bot_u_d;
  logic [PW-1:0] presc_q, presc_d;
  logic set_q, conti_q;
  logic set_rise, conti_rise, tick, tgt_nz, full_hit, full_evt;

  bcd_t l6_q, l5_q, l4_q, l3_q, l2_q, disp_hi_d, disp_lo_d;
  logic [6:0] seg_q, seg_d;
  logic speaker_q, speaker_d;

  bcd_t set_high, set_low;
  assign set_high = {set_high_D, set_high_C, set_high_B, set_high_A};
  assign set_low  = {set_low_D, set_low_C, set_low_B, set_low_A};

  always_comb begin
    set_rise   = SET & ~set_q;
    conti_rise = conti & ~conti_q;
    tick       = (state_q == ST_FILL) && (presc_q == PRESC_LAST);
    tgt_nz     = {tgt_hi_q, tgt_lo_q} != 8'h00;
    // A target lowered below the current count cannot be met by equality, so it fires on the next tick.
    full_hit   = (state_q == ST_FILL) &&
                 (({pill_hi_q, pill_lo_q} == {tgt_hi_q, tgt_lo_q}) ||
                  (tick && ({pill_hi_q, pill_lo_q} > {tgt_hi_q, tgt_lo_q})));
  end

  always_comb begin
    state_d   = state_q;
    tgt_hi_d  = tgt_hi_q;
    tgt_lo_d  = tgt_lo_q;
    pill_hi_d = pill_hi_q;
    pill_lo_d = pill_lo_q;
    bot_h_d   = bot_h_q;
    bot_t_d   = bot_t_q;
    bot_u_d   = bot_u_q;
    presc_d   = presc_q;
    full_evt  = 1'b0;

    if (state_q == ST_FILL) presc_d = tick ? '0 : presc_q + 1'b1;

    if (!isWork) begin
      state_d   = ST_IDLE;
      pill_hi_d = '0;
      pill_lo_d = '0;
    end else if (EN_set) begin
      state_d = ST_SETUP;
      if (set_rise) begin
        tgt_hi_d = bcd_clamp(set_high);
        tgt_lo_d = bcd_clamp(set_low);
      end
    end else if (full_hit) begin
      state_d   = ST_FULL;
      full_evt  = 1'b1;
      pill_hi_d = '0;
      pill_lo_d = '0;
      bot_u_d   = bcd_step(bot_u_q, 1'b1);
      bot_t_d   = bcd_step(bot_t_q, bot_u_q == BCD_MAX);
      bot_h_d   = bcd_step(bot_h_q, (bot_u_q == BCD_MAX) && (bot_t_q == BCD_MAX));
    end else begin
      if (tick) begin
        pill_lo_d = bcd_step(pill_lo_q, 1'b1);
        pill_hi_d = bcd_step(pill_hi_q, pill_lo_q == BCD_MAX);
      end
      // A held conti level auto-continues; otherwise a fresh strobe releases FULL.
      if ((state_q == ST_FULL) && !(conti || conti_rise)) state_d = ST_FULL;
      else if (EN_work && tgt_nz)                         state_d = ST_FILL;
      else                                                state_d = ST_PAUSE;
    end
  end

  always_comb begin
    disp_hi_d = PrintB ? tgt_hi_d : pill_hi_d;
    disp_lo_d = PrintB ? tgt_lo_d : pill_lo_d;
  end

  bottle_seg7 u_seg7 (
    .digit_i ({1'b0, state_d}),
    .seg_o   (seg_d)
  );

`ifdef BOTTLE_ALARM_EN
  localparam int AW = (ALARM_CYC > 0) ? $clog2(ALARM_CYC + 1) : 1;
  logic music_s1_q, music_s2_q;
  logic [AW-1:0] alarm_q;

  always_ff @(posedge CLK_org or negedge rst_n) begin
    if (!rst_n) begin
      music_s1_q <= 1'b0;
      music_s2_q <= 1'b0;
      alarm_q    <= '0;
    end else begin
      music_s1_q <= CLK_Music;
      music_s2_q <= music_s1_q;
      if (full_evt)          alarm_q <= AW'(ALARM_CYC);
      else if (alarm_q != 0) alarm_q <= alarm_q - 1'b1;
    end
  end

  assign speaker_d = music_s2_q & mode_EN & (alarm_q != '0);
`else
  logic unused_alarm;
  assign unused_alarm = ^{CLK_Music, mode_EN, full_evt};
  assign speaker_d    = 1'b0;
`endif

  always_ff @(posedge CLK_org or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tgt_hi_q  <= '0;
      tgt_lo_q  <= '0;
      pill_hi_q <= '0;
      pill_lo_q <= '0;
      bot_h_q   <= '0;
      bot_t_q   <= '0;
      bot_u_q   <= '0;
      presc_q   <= '0;
      set_q     <= 1'b0;
      conti_q   <= 1'b0;
      l6_q      <= '0;
      l5_q      <= '0;
      l4_q      <= '0;
      l3_q      <= '0;
      l2_q      <= '0;
      seg_q     <= 7'b1111110;
      speaker_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_hi_q  <= tgt_hi_d;
      tgt_lo_q  <= tgt_lo_d;
      pill_hi_q <= pill_hi_d;
      pill_lo_q <= pill_lo_d;
      bot_h_q   <= bot_h_d;
      bot_t_q   <= bot_t_d;
      bot_u_q   <= bot_u_d;
      presc_q   <= presc_d;
      set_q     <= SET;
      conti_q   <= conti;
      // Displays are registered from next-state values so they line up with the internal state.
      l6_q      <= bot_h_d;
      l5_q      <= bot_t_d;
      l4_q      <= bot_u_d;
      l3_q      <= disp_hi_d;
      l2_q      <= disp_lo_d;
      seg_q     <= seg_d;
      speaker_q <= speaker_d;
    end
  end

  assign {light6_D, light6_C, light6_B, light6_A} = l6_q;
  assign {light5_D, light5_C, light5_B, light5_A} = l5_q;
  assign {light4_D, light4_C, light4_B, light4_A} = l4_q;
  assign {light3_D, light3_C, light3_B, light3_A} = l3_q;
  assign {light2_D, light2_C, light2_B, light2_A} = l2_q;
  assign {light1_a, light1_b, light1_c, light1_d, light1_e, light1_f, light1_g} = seg_q;
  assign Speaker = speaker_q;

endmodule

// File: tb/tb_bottle.sv
// Scoreboard bench for bottle: stimulus queues expected bottle counts, a monitor checks each full event.
module tb_bottle;

  logic CLK_org, rst_n, CLK_Music, isWork, EN_work, EN_set, SET, conti, PrintB, mode_EN;
  logic [3:0] set_high, set_low;
  logic l6D, l6C, l6B, l6A, l5D, l5C, l5B, l5A, l4D, l4C, l4B, l4A;
  logic l3D, l3C, l3B, l3A, l2D, l2C, l2B, l2A;
  logic sa, sb_, sc, sd, se, sf, sg, Speaker;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G4 = 7'b0110011;
`ifdef BOTTLE_ALARM_EN
  localparam int EXP_SPK = 16;
`else
  localparam int EXP_SPK = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb[$];

  bottle #(.PILL_DIV(4), .ALARM_CYC(16)) dut (
    .CLK_org(CLK_org), .rst_n(rst_n), .CLK_Music(CLK_Music), .isWork(isWork),
    .EN_work(EN_work), .EN_set(EN_set), .SET(SET), .conti(conti), .PrintB(PrintB),
    .mode_EN(mode_EN),
    .set_high_D(set_high[3]), .set_high_C(set_high[2]), .set_high_B(set_high[1]), .set_high_A(set_high[0]),
    .set_low_D(set_low[3]), .set_low_C(set_low[2]), .set_low_B(set_low[1]), .set_low_A(set_low[0]),
    .light6_D(l6D), .light6_C(l6C), .light6_B(l6B), .light6_A(l6A),
    .light5_D(l5D), .light5_C(l5C), .light5_B(l5B), .light5_A(l5A),
    .light4_D(l4D), .light4_C(l4C), .light4_B(l4B), .light4_A(l4A),
    .light3_D(l3D), .light3_C(l3C), .light3_B(l3B), .light3_A(l3A),
    .light2_D(l2D), .light2_C(l2C), .light2_B(l2B), .light2_A(l2A),
    .light1_a(sa), .light1_b(sb_), .light1_c(sc), .light1_d(sd),
    .light1_e(se), .light1_f(sf), .light1_g(sg),
    .Speaker(Speaker)
  );

  initial begin
    CLK_org = 1'b0;
    forever #5 CLK_org = ~CLK_org;
  end

  function automatic logic [11:0] bottle_now();
    return {l6D, l6C, l6B, l6A, l5D, l5C, l5B, l5A, l4D, l4C, l4B, l4A};
  endfunction
  function automatic logic [7:0] pill_now();
    return {l3D, l3C, l3B, l3A, l2D, l2C, l2B, l2A};
  endfunction
  function automatic logic [6:0] seg_now();
    return {sa, sb_, sc, sd, se, sf, sg};
  endfunction
  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_org);
    #1;
  endtask

  // sel: 0 = state glyph, 1 = pill display, 2 = bottle count
  task automatic wait_for(input int sel, input logic [11:0] val, input int max, input string name);
    bit hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge CLK_org);
      case (sel)
        0:       hit = (seg_now() == val[6:0]);
        1:       hit = (pill_now() == val[7:0]);
        default: hit = (bottle_now() == val);
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL %s: timeout after %0d cycles waiting for %0h", name, max, val);
    end
  endtask

  task automatic pulse_conti();
    @(negedge CLK_org);
    conti = 1'b1;
    @(negedge CLK_org);
    conti = 1'b0;
  endtask

  task automatic count_speaker(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge CLK_org);
      if (Speaker === 1'b1) cnt++;
    end
  endtask

  // Monitor: every entry into FULL is one transaction, checked against the queued bottle count.
  initial begin : monitor
    logic prev_full, cur_full;
    logic [11:0] exp;
    prev_full = 1'b0;
    forever begin
      @(negedge CLK_org);
      cur_full = rst_n && (seg_now() == G4);
      if (cur_full && !prev_full) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL full_event: unexpected bottle full, bottle=%03h", bottle_now());
        end else begin
          exp = sb.pop_front();
          if (bottle_now() !== exp) begin
            n_errors++;
            $display("FAIL full_event: bottle got %03h expected %03h", bottle_now(), exp);
          end else begin
            $display("ok   full_event: bottle %03h", exp);
          end
        end
      end
      prev_full = cur_full;
    end
  end

  initial begin
    int spk;
    bit hit;
    rst_n = 0; CLK_Music = 0; isWork = 0; EN_work = 0; EN_set = 0; SET = 0;
    conti = 0; PrintB = 0; mode_EN = 0; set_high = 4'h0; set_low = 4'h0;

    cyc(3);
    check("reset_bottle", bottle_now(), 12'h000);
    check("reset_pill", pill_now(), 8'h00);
    check("reset_glyph", seg_now(), G0);
    check("reset_speaker", Speaker, 1'b0);
    rst_n = 1;
    cyc(1);

    // Setup with a clamped units digit: 0,F -> 09
    isWork = 1; EN_set = 1; set_high = 4'h0; set_low = 4'hF;
    cyc(1);
    SET = 1; PrintB = 1;
    cyc(1);
    SET = 0;
    cyc(1);
    check("setup_target_09", pill_now(), 8'h09);
    check("setup_glyph", seg_now(), G1);

    set_low = 4'h3;
    SET = 1;
    cyc(1);
    SET = 0;
    cyc(1);
    check("setup_target_03", pill_now(), 8'h03);

    // Fill with auto-continue: pill 3 after 12 FILL cycles, one FULL cycle, back to FILL
    sb.push_back(12'h001);
    EN_set = 0; EN_work = 1; conti = 1; PrintB = 0;
    cyc(12);
    check("fill_pill_at_12", pill_now(), 8'h02);
    cyc(1);
    check("fill_pill_at_13", pill_now(), 8'h03);
    check("fill_glyph", seg_now(), G2);
    cyc(1);
    check("full_glyph", seg_now(), G4);
    check("full_bottle", bottle_now(), 12'h001);
    check("full_pill_clear", pill_now(), 8'h00);
    cyc(1);
    check("autocontinue_glyph", seg_now(), G2);
    conti = 0;

    // Without conti FULL holds until a strobe
    sb.push_back(12'h002);
    wait_for(0, {5'd0, G4}, 100, "wait_full_2");
    repeat (5) @(negedge CLK_org);
    check("full_hold_glyph", seg_now(), G4);
    pulse_conti();
    check("resume_glyph", seg_now(), G2);
    repeat (3) @(negedge CLK_org);
    check("resume_bottle_hold", bottle_now(), 12'h002);

    // Drop power mid-fill at pill 2
    wait_for(1, 12'h002, 60, "wait_pill_2");
    isWork = 0;
    @(negedge CLK_org);
    check("idle_glyph", seg_now(), G0);
    check("idle_pill_clear", pill_now(), 8'h00);
    check("idle_bottle_hold", bottle_now(), 12'h002);

    // Both digits clamp: C,A -> 99
    isWork = 1; EN_set = 1; set_high = 4'hC; set_low = 4'hA; PrintB = 1;
    @(negedge CLK_org);
    SET = 1;
    @(negedge CLK_org);
    SET = 0;
    @(negedge CLK_org);
    check("clamp_target_99", pill_now(), 8'h99);

    set_high = 4'h0; set_low = 4'h3; SET = 1;
    @(negedge CLK_org);
    SET = 0; PrintB = 0; EN_set = 0;
    @(negedge CLK_org);
    check("refill_glyph", seg_now(), G2);

    // Lower the target below the current count while filling
    wait_for(1, 12'h002, 60, "wait_pill_2b");
    EN_set = 1; set_low = 4'h1;
    @(negedge CLK_org);
    SET = 1;
    @(negedge CLK_org);
    SET = 0; PrintB = 1;
    @(negedge CLK_org);
    check("reload_target_01", pill_now(), 8'h01);
    check("reload_glyph", seg_now(), G1);
    sb.push_back(12'h003);
    PrintB = 0; EN_set = 0;
    wait_for(0, {5'd0, G4}, 20, "wait_full_reload");
    @(negedge CLK_org);
    check("reload_pill_clear", pill_now(), 8'h00);

    // Run up to 999 and wrap to 000
    for (int n = 4; n <= 1000; n++) sb.push_back(to_bcd(n % 1000));
    conti = 1;
    hit = 0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge CLK_org);
      if (bottle_now() == 12'h000) begin
        conti = 0;
        hit = 1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL wrap_timeout: bottle count never wrapped to 000, now %03h", bottle_now());
      conti = 0;
    end
    @(negedge CLK_org);
    check("wrap_full_hold", seg_now(), G4);
    check("wrap_queue_empty", sb.size(), 0);

    // Alarm: mode_EN=1 with a steady tone, then mode_EN=0
    repeat (30) @(negedge CLK_org);
    check("alarm_idle", Speaker, 1'b0);
    mode_EN = 1; CLK_Music = 1;
    sb.push_back(12'h001);
    pulse_conti();
    count_speaker(60, spk);
    check("alarm_on_cycles", spk, EXP_SPK);
    mode_EN = 0;
    sb.push_back(12'h002);
    pulse_conti();
    count_speaker(60, spk);
    check("alarm_muted_cycles", spk, 0);

    // Asynchronous reset between clock edges
    @(negedge CLK_org);
    #2 rst_n = 0;
    #1;
    check("async_bottle", bottle_now(), 12'h000);
    check("async_glyph", seg_now(), G0);
    check("async_pill", pill_now(), 8'h00);
    check("async_speaker", Speaker, 1'b0);
    cyc(2);
    rst_n = 1;
    cyc(2);
    check("final_queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
